// File: rtl/dcdl_code_ctrl.sv
// dcdl_code_ctrl
//   Thermometer control code generator for the FMDLL digitally controlled
//   delay line. It acquires lock with a binary (SAR) search driven by the
//   bang-bang phase detector. After that it tracks drift with filtered +/-1
//   steps and reports a sticky lock flag.
//
// Ports
//   clk_i          single clock for all state
//   rst_i          asynchronous, active-high reset
//   en_i           run enable; low returns the controller to IDLE
//   pd_valid_i     phase-detector decision strobe, one cycle wide
//   pd_up_i        delay too short: add delay
//   pd_dn_i        delay too long: remove delay
//   code_o         current binary delay code
//   t_o            thermometer code, t_o[i] = 1 iff code_o > i
//   tb_o           bitwise complement of t_o
//   search_done_o  SAR search finished (high in TRACK)
//   locked_o       lock achieved; sticky until en_i low or rst_i
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | disabled; code/T/Tb hold, flags and tracking state cleared
// SAR    | binary search, one code bit resolved per valid vote
// TRACK  | filtered +/-1 tracking, reversal counting for lock
module dcdl_code_ctrl #(
  parameter int CODE_W   = 5,
  parameter int FILT     = 4,
  parameter int LOCK_REV = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     en_i,
  input  logic                     pd_valid_i,
  input  logic                     pd_up_i,
  input  logic                     pd_dn_i,
  output logic [CODE_W-1:0]        code_o,
  output logic [(2**CODE_W)-2:0]   t_o,
  output logic [(2**CODE_W)-2:0]   tb_o,
  output logic                     search_done_o,
  output logic                     locked_o
);

  localparam int N  = (2**CODE_W) - 1;
  localparam int PW = (CODE_W > 1) ? $clog2(CODE_W) : 1;
  // One extra bit beyond the magnitude so that +/-FILT are both representable.
  localparam int FW = $clog2(FILT + 1) + 1;
  localparam int RW = (LOCK_REV > 1) ? $clog2(LOCK_REV + 1) : 1;

  localparam logic [CODE_W-1:0] CODE_MID = CODE_W'(1) << (CODE_W - 1);
  localparam logic [CODE_W-1:0] CODE_MAX = {CODE_W{1'b1}};
  localparam logic [PW-1:0]     PTR_MSB  = PW'(CODE_W - 1);
  localparam logic [FW-1:0]     FILT_POS = FW'(FILT);
  localparam logic [FW-1:0]     FILT_NEG = FW'(-FILT);
  localparam logic [RW-1:0]     REV_MAX  = RW'(LOCK_REV);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SAR   = 2'd1,
    ST_TRACK = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [FW-1:0]       filt_q, filt_d, filt_nx;
  logic [RW-1:0]       rev_q, rev_d;
  logic                have_step_q, have_step_d;
  logic                last_up_q, last_up_d;
  logic                done_q, done_d;
  logic                locked_q, locked_d;
  logic [N-1:0]        t_q, t_d;
  logic [N-1:0]        tb_q;

  logic vote_up, vote_dn, vote;

  // A vote with both or neither direction asserted carries no information.
  assign vote_up = pd_valid_i &  pd_up_i & ~pd_dn_i;
  assign vote_dn = pd_valid_i & ~pd_up_i &  pd_dn_i;
  assign vote    = vote_up | vote_dn;

  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    ptr_d       = ptr_q;
    filt_d      = filt_q;
    filt_nx     = filt_q;
    rev_d       = rev_q;
    have_step_d = have_step_q;
    last_up_d   = last_up_q;
    done_d      = done_q;
    locked_d    = locked_q;

    if (!en_i) begin
      // code is intentionally held so the delay line keeps its last setting.
      state_d     = ST_IDLE;
      done_d      = 1'b0;
      locked_d    = 1'b0;
      filt_d      = '0;
      rev_d       = '0;
      have_step_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d     = ST_SAR;
          code_d      = CODE_MID;
          ptr_d       = PTR_MSB;
          done_d      = 1'b0;
          locked_d    = 1'b0;
          filt_d      = '0;
          rev_d       = '0;
          have_step_d = 1'b0;
        end

        ST_SAR: begin
          if (vote) begin
            if (vote_dn) code_d[ptr_q] = 1'b0;
            if (ptr_q != '0) begin
              code_d[ptr_q - 1'b1] = 1'b1;
              ptr_d                = ptr_q - 1'b1;
            end else begin
              state_d = ST_TRACK;
              done_d  = 1'b1;
            end
          end
        end

        ST_TRACK: begin
          if (vote) begin
            filt_nx = vote_up ? (filt_q + 1'b1) : (filt_q - 1'b1);
            filt_d  = filt_nx;
            if (filt_nx == FILT_POS) begin
              filt_d = '0;
              // A saturated hit clears the filter but is not a step.
              if (code_q != CODE_MAX) begin
                code_d = code_q + 1'b1;
                if (have_step_q && !last_up_q && (rev_q != REV_MAX))
                  rev_d = rev_q + 1'b1;
                have_step_d = 1'b1;
                last_up_d   = 1'b1;
              end
            end else if (filt_nx == FILT_NEG) begin
              filt_d = '0;
              if (code_q != '0) begin
                code_d = code_q - 1'b1;
                if (have_step_q && last_up_q && (rev_q != REV_MAX))
                  rev_d = rev_q + 1'b1;
                have_step_d = 1'b1;
                last_up_d   = 1'b0;
              end
            end
          end
          if (rev_d >= REV_MAX) locked_d = 1'b1;
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  // T and Tb are registered from the next code so both change on the same
  // edge as code and never glitch through a decoder.
  always_comb begin
    t_d = '0;
    for (int i = 0; i < N; i++) begin
      t_d[i] = (int'(code_d) > i);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      code_q      <= '0;
      ptr_q       <= PTR_MSB;
      filt_q      <= '0;
      rev_q       <= '0;
      have_step_q <= 1'b0;
      last_up_q   <= 1'b0;
      done_q      <= 1'b0;
      locked_q    <= 1'b0;
      t_q         <= '0;
      tb_q        <= '1;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      ptr_q       <= ptr_d;
      filt_q      <= filt_d;
      rev_q       <= rev_d;
      have_step_q <= have_step_d;
      last_up_q   <= last_up_d;
      done_q      <= done_d;
      locked_q    <= locked_d;
      t_q         <= t_d;
      tb_q        <= ~t_d;
    end
  end

  assign code_o        = code_q;
  assign t_o           = t_q;
  assign tb_o          = tb_q;
  assign search_done_o = done_q;
  assign locked_o      = locked_q;

endmodule

// File: tb/tb_dcdl_code_ctrl.sv
// Testbench for dcdl_code_ctrl: directed scenarios plus a randomized run
// compared against a behavioural model of the search/track rules.
module tb_dcdl_code_ctrl;

  localparam int CODE_W   = 5;
  localparam int FILT     = 4;
  localparam int LOCK_REV = 2;
  localparam int N        = (2**CODE_W) - 1;
  localparam int MAXC     = (2**CODE_W) - 1;
  localparam int MID      = 2**(CODE_W - 1);
  localparam int VW       = CODE_W + 2*N + 2;

  logic              clk = 1'b0;
  logic              rst_i, en_i, pd_valid_i, pd_up_i, pd_dn_i;
  logic [CODE_W-1:0] code_o;
  logic [N-1:0]      t_o, tb_o;
  logic              search_done_o, locked_o;
  logic [VW-1:0]     obs;

  int checks = 0;
  int errors = 0;

  // model state
  int m_state;   // 0 idle, 1 search, 2 track
  int m_code, m_bit, m_filt, m_last, m_rev, target;
  bit m_done, m_lock;

  dcdl_code_ctrl #(.CODE_W(CODE_W), .FILT(FILT), .LOCK_REV(LOCK_REV)) dut (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i),
    .pd_valid_i(pd_valid_i), .pd_up_i(pd_up_i), .pd_dn_i(pd_dn_i),
    .code_o(code_o), .t_o(t_o), .tb_o(tb_o),
    .search_done_o(search_done_o), .locked_o(locked_o)
  );

  always #5 clk = ~clk;

  assign obs = {code_o, t_o, tb_o, search_done_o, locked_o};

  function automatic logic [N-1:0] therm(input int c);
    logic [63:0] ones;
    ones = (64'd1 << c) - 64'd1;
    return ones[N-1:0];
  endfunction

  function automatic logic [VW-1:0] expv(input int c, input bit d, input bit l);
    logic [CODE_W-1:0] cc;
    cc = CODE_W'(c);
    return {cc, therm(c), ~therm(c), d, l};
  endfunction

  task automatic step(input bit v, input bit u, input bit d);
    pd_valid_i = v; pd_up_i = u; pd_dn_i = d;
    @(posedge clk);
    #1;
    pd_valid_i = 1'b0; pd_up_i = 1'b0; pd_dn_i = 1'b0;
  endtask

  task automatic restart();
    en_i = 1'b0;
    step(0, 0, 0);
    en_i = 1'b1;
    step(0, 0, 0);
  endtask

  // Reference model: one clock edge of behaviour from the rules.
  task automatic model_cycle(input bit en, input bit v, input bit u, input bit d);
    int b;
    if (!en) begin
      m_state = 0; m_done = 0; m_lock = 0; m_filt = 0; m_rev = 0; m_last = 0;
    end else if (m_state == 0) begin
      m_state = 1; m_code = MID; m_bit = CODE_W - 1;
      m_done = 0; m_lock = 0; m_filt = 0; m_rev = 0; m_last = 0;
    end else if (v && (u != d)) begin
      if (m_state == 1) begin
        // Votes are generated consistent with target, so after deciding bit b
        // the code is target's prefix down to b plus the next trial bit.
        b = m_bit;
        m_code = ((target >> b) << b) | ((b > 0) ? (1 << (b - 1)) : 0);
        if (b == 0) begin m_state = 2; m_done = 1; end
        else m_bit = b - 1;
      end else begin
        m_filt += u ? 1 : -1;
        if (m_filt == FILT) begin
          m_filt = 0;
          if (m_code < MAXC) begin
            m_code++;
            if (m_last == -1) m_rev++;
            m_last = 1;
          end
        end else if (m_filt == -FILT) begin
          m_filt = 0;
          if (m_code > 0) begin
            m_code--;
            if (m_last == 1) m_rev++;
            m_last = -1;
          end
        end
        if (m_rev >= LOCK_REV) m_lock = 1;
      end
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (obs !== expv(0, 0, 0)) begin
      errors++;
      $display("FAIL reset_hold: got %h want %h", obs, expv(0, 0, 0));
    end
    @(negedge clk);
    rst_i = 1'b0;
    step(0, 0, 0);
    checks++;
    if (obs !== expv(0, 0, 0)) begin
      errors++;
      $display("FAIL reset_release: got %h want %h", obs, expv(0, 0, 0));
    end
    // async reset in the middle of a search with code 24
    restart();
    step(1, 1, 0);
    checks++;
    if (code_o !== 5'd24) begin
      errors++;
      $display("FAIL pre_reset_code: got %0d want 24", code_o);
    end
    #2;
    rst_i = 1'b1;
    #1;
    checks++;
    if (obs !== expv(0, 0, 0)) begin
      errors++;
      $display("FAIL async_reset: got %h want %h", obs, expv(0, 0, 0));
    end
    en_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b0;
    step(0, 0, 0);
  endtask

  task automatic test_sar_target19();
    bit ups[5]   = '{1, 0, 0, 1, 1};
    int exps[5]  = '{24, 20, 18, 19, 19};
    restart();
    checks++;
    if (obs !== expv(MID, 0, 0)) begin
      errors++;
      $display("FAIL sar_midpoint: got %h want %h", obs, expv(MID, 0, 0));
    end
    for (int i = 0; i < 5; i++) begin
      step(1, ups[i], !ups[i]);
      checks++;
      if (obs !== expv(exps[i], i == 4, 0)) begin
        errors++;
        $display("FAIL sar19_vote%0d: got %h want %h", i, obs, expv(exps[i], i == 4, 0));
      end
    end
    checks++;
    if (t_o !== 31'h0007FFFF || tb_o !== ~31'h0007FFFF) begin
      errors++;
      $display("FAIL sar19_therm: got T=%h Tb=%h want T=0007ffff", t_o, tb_o);
    end
  endtask

  task automatic test_track_lock();
    bit dirs[3] = '{1, 0, 1};
    int exp_c = 19;
    for (int g = 0; g < 3; g++) begin
      for (int j = 0; j < FILT; j++) begin
        step(1, dirs[g], !dirs[g]);
        if (j == FILT - 1) exp_c += dirs[g] ? 1 : -1;
        checks++;
        if (obs !== expv(exp_c, 1, (g == 2) && (j == FILT - 1))) begin
          errors++;
          $display("FAIL track_g%0d_v%0d: got %h want %h", g, j, obs,
                   expv(exp_c, 1, (g == 2) && (j == FILT - 1)));
        end
      end
    end
  endtask

  task automatic test_null_votes();
    restart();
    step(1, 1, 0);
    checks++;
    if (code_o !== 5'd24) begin
      errors++;
      $display("FAIL null_first: got %0d want 24", code_o);
    end
    step(1, 1, 1);
    step(1, 0, 0);
    step(0, 1, 0);
    checks++;
    if (obs !== expv(24, 0, 0)) begin
      errors++;
      $display("FAIL null_hold: got %h want %h", obs, expv(24, 0, 0));
    end
    step(1, 0, 1);
    checks++;
    if (code_o !== 5'd20) begin
      errors++;
      $display("FAIL null_resume: got %0d want 20", code_o);
    end
  endtask

  task automatic test_saturation();
    bit dirs[4]  = '{1, 0, 1, 0};
    int exp_c;
    bit lk;
    restart();
    for (int i = 0; i < CODE_W; i++) step(1, 1, 0);
    checks++;
    if (obs !== expv(MAXC, 1, 0) || t_o !== {N{1'b1}}) begin
      errors++;
      $display("FAIL sat_search: got %h want %h", obs, expv(MAXC, 1, 0));
    end
    // saturated up hit, then dn / up / dn steps: only dn->up->dn reversals count
    exp_c = MAXC;
    lk = 0;
    for (int g = 0; g < 4; g++) begin
      for (int j = 0; j < FILT; j++) begin
        step(1, dirs[g], !dirs[g]);
        if (j == FILT - 1 && g > 0) exp_c += dirs[g] ? 1 : -1;
        if (g == 3 && j == FILT - 1) lk = 1;
        checks++;
        if (obs !== expv(exp_c, 1, lk)) begin
          errors++;
          $display("FAIL sat_g%0d_v%0d: got %h want %h", g, j, obs, expv(exp_c, 1, lk));
        end
      end
    end
  endtask

  task automatic test_en_drop();
    en_i = 1'b0;
    step(1, 1, 0);
    checks++;
    if (obs !== expv(MAXC - 1, 0, 0)) begin
      errors++;
      $display("FAIL en_drop: got %h want %h", obs, expv(MAXC - 1, 0, 0));
    end
    step(1, 0, 1);
    checks++;
    if (obs !== expv(MAXC - 1, 0, 0)) begin
      errors++;
      $display("FAIL en_low_hold: got %h want %h", obs, expv(MAXC - 1, 0, 0));
    end
    en_i = 1'b1;
    step(0, 0, 0);
    checks++;
    if (obs !== expv(MID, 0, 0)) begin
      errors++;
      $display("FAIL en_restart: got %h want %h", obs, expv(MID, 0, 0));
    end
    step(1, 1, 0);
    checks++;
    if (code_o !== 5'd24) begin
      errors++;
      $display("FAIL en_restart_vote: got %0d want 24", code_o);
    end
  endtask

  task automatic test_random();
    bit v, u, d, en, drop;
    int r;
    for (int it = 0; it < 20; it++) begin
      target = $urandom_range(0, MAXC);
      drop = it[0];
      restart();
      m_state = 1; m_code = MID; m_bit = CODE_W - 1;
      m_filt = 0; m_rev = 0; m_last = 0; m_done = 0; m_lock = 0;
      for (int cyc = 0; cyc < 200; cyc++) begin
        if (m_state == 2 && cyc % 40 == 0) target = $urandom_range(0, MAXC);
        en = !(drop && (cyc == 120 || cyc == 121));
        r = $urandom_range(0, 9);
        if (r < 2) begin
          v = 0; u = $urandom_range(0, 1); d = $urandom_range(0, 1);
        end else if (r == 2) begin
          v = 1; u = $urandom_range(0, 1); d = u;
        end else begin
          v = 1;
          if (m_state == 1) u = (m_code <= target);
          else if (m_code < target) u = ($urandom_range(0, 9) < 7);
          else if (m_code > target) u = ($urandom_range(0, 9) < 3);
          else u = $urandom_range(0, 1);
          d = !u;
        end
        en_i = en;
        step(v, u, d);
        model_cycle(en, v, u, d);
        checks++;
        if (obs !== expv(m_code, m_done, m_lock)) begin
          errors++;
          $display("FAIL random it%0d cyc%0d: got %h want %h", it, cyc, obs,
                   expv(m_code, m_done, m_lock));
        end
      end
    end
  endtask

  initial begin
    rst_i = 1'b1; en_i = 1'b0;
    pd_valid_i = 1'b0; pd_up_i = 1'b0; pd_dn_i = 1'b0;
    test_reset();
    test_sar_target19();
    test_track_lock();
    test_null_votes();
    test_saturation();
    test_en_drop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
